// File: rtl/ahb_mem_fill_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ahb_mem_fill_bridge_pkg
// Brief   : Shared AHB-Lite encodings (HTRANS, HRESP) for the fill bridge.
// Revision: 1.0 - initial release
// ============================================================================
package ahb_mem_fill_bridge_pkg;

    localparam logic [1:0] c_htrans_idle = 2'b00;
    localparam logic [1:0] c_htrans_busy = 2'b01;
    localparam logic [1:0] c_htrans_nseq = 2'b10;
    localparam logic [1:0] c_htrans_seq  = 2'b11;

    localparam logic c_hresp_okay  = 1'b0;
    localparam logic c_hresp_error = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ahb_mem_fill_bridge.sv
`default_nettype none
// ============================================================================
// Module  : ahb_mem_fill_bridge
// Brief   : AHB-Lite read-only slave that fills each beat from a req/ack memory.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_mem_fill_bridge
    import ahb_mem_fill_bridge_pkg::*;
#(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              src_hready_resp,
    input  logic              src_hready,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    output logic              mem_req,
    output logic [W_ADDR-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [W_DATA-1:0] mem_rdata,
    input  logic              mem_err
);

    localparam int c_size_lg = $clog2(W_DATA / 8);
    localparam int c_cnt_w   = $clog2(TIMEOUT + 1);
    localparam logic [W_ADDR-1:0] c_addr_mask = W_ADDR'((64'd1 << c_size_lg) - 64'd1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_ERR_PH0 = 3'd3;
    localparam logic [2:0] S_ERR_PH1 = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [W_ADDR-1:0]  r_addr;
    logic [W_DATA-1:0]  r_hold;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;
    logic               w_valid;
    logic               w_load_addr;
    logic               w_capture;
    logic               w_unused_ok;

    assign w_accept = src_hready &&
                      ((src_htrans == c_htrans_nseq) || (src_htrans == c_htrans_seq));
    assign w_valid  = !src_hwrite && (src_hsize == 3'(c_size_lg)) &&
                      ((src_haddr & c_addr_mask) == '0);

    assign w_unused_ok = ^{src_hburst, src_hprot, src_hmastlock, src_hwdata};

    always_comb begin
        w_next      = r_state;
        w_load_addr = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE, S_DATA, S_ERR_PH1: begin
                if (w_accept) begin
                    w_next      = w_valid ? S_WAIT : S_ERR_PH0;
                    w_load_addr = w_valid;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                // An ack landing on the final counted cycle still wins over the timeout.
                if (mem_ack) begin
                    w_next    = mem_err ? S_ERR_PH0 : S_DATA;
                    w_capture = !mem_err;
                end else if (r_cnt == c_cnt_last) begin
                    w_next = S_ERR_PH0;
                end
            end
            S_ERR_PH0: w_next = S_ERR_PH1;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_hold  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + c_cnt_w'(1) : '0;
            if (w_load_addr) begin
                r_addr <= src_haddr;
            end
            if (w_capture) begin
                r_hold <= mem_rdata;
            end
        end
    end

    // mem_req is decoded from the state so an asynchronous reset aborts it at once.
    assign mem_req         = (r_state == S_WAIT);
    assign mem_addr        = r_addr & ~c_addr_mask;
    assign src_hrdata      = r_hold;
    assign src_hready_resp = (r_state == S_IDLE) || (r_state == S_DATA) ||
                             (r_state == S_ERR_PH1);
    assign src_hresp       = ((r_state == S_ERR_PH0) || (r_state == S_ERR_PH1)) ?
                             c_hresp_error : c_hresp_okay;

endmodule
`default_nettype wire
